// File: rtl/uart_program_loader.sv
// uart_program_loader: streams received UART bytes into program sram from address 0, then writes a 0x00 end marker and raises done.
// Define LOADER_FILTER_EN to store only the eight command bytes + - < > [ ] . , and discard every other non-terminator byte.
module uart_program_loader #(
   parameter int         ADDR_WIDTH   = 10,
   parameter logic [7:0] TERM_CHAR    = 8'h21,
   parameter int         IDLE_TIMEOUT = 86800
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start_load,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_data,
   output logic                  loading,
   output logic                  done,
   output logic                  overflow,
   output logic [ADDR_WIDTH-1:0] prog_len
);
   localparam int CW = IDLE_TIMEOUT < 2 ? 1 : $clog2(IDLE_TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, WAIT_BYTE, WRITE, TERM, DONE} state_t;
   state_t state, state_n;
   logic prev_start, start_edge, storable, full, tmo, armed;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [CW-1:0] cnt;
`ifdef LOADER_FILTER_EN
   assign storable = rx_data inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C};
`else
   assign storable = rx_data != TERM_CHAR;
`endif
   assign start_edge = start_load & ~prev_start;
   assign full       = &ptr;
   // cnt holds the number of clocks since the last byte, so TERM lands IDLE_TIMEOUT clocks after it
   assign tmo        = IDLE_TIMEOUT != 0 && armed && cnt >= CW'(IDLE_TIMEOUT - 1);
   assign mem_write  = state == WRITE || state == TERM;
   assign loading    = state == WAIT_BYTE || state == WRITE;
   assign done       = state == TERM || state == DONE;
   assign prog_len   = ptr;
   always_comb begin
      state_n = state;
      if (start_edge)
         state_n = WAIT_BYTE;
      else if (state == WAIT_BYTE && rx_valid)
         state_n = rx_data == TERM_CHAR ? TERM : !storable ? WAIT_BYTE : full ? TERM : WRITE;
      else if (state == WAIT_BYTE && tmo)
         state_n = TERM;
      else if (state == WRITE)
         state_n = WAIT_BYTE;
      else if (state == TERM)
         state_n = DONE;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         prev_start <= 1'b0;
         ptr        <= '0;
         cnt        <= '0;
         armed      <= 1'b0;
         overflow   <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
      end else begin
         state      <= state_n;
         prev_start <= start_load;
         if (start_edge) begin
            ptr      <= '0;
            cnt      <= '0;
            armed    <= 1'b0;
            overflow <= 1'b0;
         end else begin
            if (state == WRITE)
               ptr <= ptr + 1'b1;
            if (state == WAIT_BYTE && rx_valid) begin
               armed <= 1'b1;
               cnt   <= CW'(1);
            end else if (state == TERM)
               armed <= 1'b0;
            else if (armed)
               cnt <= cnt + 1'b1;
            if (state == WAIT_BYTE && rx_valid && rx_data != TERM_CHAR && storable && full)
               overflow <= 1'b1;
         end
         if (state_n == WRITE || (state_n == TERM && state == WAIT_BYTE)) begin
            mem_addr <= ptr;
            mem_data <= state_n == WRITE ? rx_data : 8'h00;
         end
      end
   end
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: random and directed loads checked against a byte-list model of the loader.
module tb_uart_program_loader;
   localparam int AW  = 3;
   localparam int TMO = 100;
   logic clock = 0, reset = 1, start_load = 0, rx_valid = 0;
   logic [7:0] rx_data = 0;
   logic mem_write, loading, done, overflow;
   logic [AW-1:0] mem_addr, prog_len;
   logic [7:0] mem_data;
   int cyc = 0, n_checks = 0, n_fail = 0;
   typedef struct {int c; int a; int d;} wr_t;
   wr_t wlog[$];

   uart_program_loader #(.ADDR_WIDTH(AW), .TERM_CHAR(8'h21), .IDLE_TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset), .start_load(start_load), .rx_data(rx_data), .rx_valid(rx_valid),
      .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data), .loading(loading),
      .done(done), .overflow(overflow), .prog_len(prog_len));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(negedge clock) if (mem_write) wlog.push_back(wr_t'{cyc, int'(mem_addr), int'(mem_data)});

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic bit is_storable(input logic [7:0] b);
`ifdef LOADER_FILTER_EN
      string cmds = "+-<>[].,";
      for (int i = 0; i < cmds.len(); i++) if (cmds[i] == b) return 1;
      return 0;
`else
      return b != 8'h21;
`endif
   endfunction

   task automatic send(input logic [7:0] b, input int gap, output int c);
      @(negedge clock);
      rx_valid = 1;
      rx_data  = b;
      c = cyc;
      @(negedge clock);
      rx_valid = 0;
      repeat (gap - 1) @(negedge clock);
   endtask

   task automatic pulse_start(input bit with_byte);
      @(negedge clock);
      start_load = 1;
      if (with_byte) begin
         rx_valid = 1;
         rx_data  = 8'h2B;
      end
      @(negedge clock);
      start_load = 0;
      rx_valid   = 0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_wr"}, mem_write, 0);
      check({tag, "_addr"}, mem_addr, 0);
      check({tag, "_data"}, mem_data, 0);
      check({tag, "_loading"}, loading, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_ovf"}, overflow, 0);
      check({tag, "_len"}, prog_len, 0);
   endtask

   task automatic run_load(input logic [7:0] b[$], input int pre_idle, input bit with_byte);
      wr_t exp[$];
      int base, len = 0, last = -1, c;
      bit ended = 0, ovf = 0;
      base = wlog.size();
      pulse_start(with_byte);
      check("start_loading", loading, 1);
      check("start_done", done, 0);
      repeat (pre_idle) @(negedge clock);
      if (pre_idle > 0) check("idle_nowrite", wlog.size() - base, 0);
      foreach (b[i]) begin
         send(b[i], $urandom_range(1, 25), c);
         if (!ended) begin
            last = c;
            if (b[i] == 8'h21) begin
               exp.push_back(wr_t'{c + 1, len, 0});
               ended = 1;
            end else if (is_storable(b[i])) begin
               if (len == 2**AW - 1) begin
                  ovf = 1;
                  exp.push_back(wr_t'{c + 1, len, 0});
                  ended = 1;
               end else begin
                  exp.push_back(wr_t'{c + 1, len, int'(b[i])});
                  len++;
               end
            end
         end
      end
      if (!ended && last >= 0) begin
         exp.push_back(wr_t'{last + TMO, len, 0});
         ended = 1;
      end
      repeat (TMO + 30) @(negedge clock);
      check("nwrites", wlog.size() - base, exp.size());
      foreach (exp[i]) if (base + i < wlog.size()) begin
         check("wr_cycle", wlog[base + i].c, exp[i].c);
         check("wr_addr", wlog[base + i].a, exp[i].a);
         check("wr_data", wlog[base + i].d, exp[i].d);
      end
      check("done", done, ended);
      check("loading", loading, !ended);
      check("prog_len", prog_len, len);
      check("overflow", overflow, ovf);
   endtask

   initial begin
      logic [7:0] q[$];
      int c;
      string pool = "+-<>[].,";
      repeat (3) @(negedge clock);
      check_zero("rst");
      reset = 0;
      run_load({8'h2B, 8'h2B, 8'h2E, 8'h21}, 0, 0);
      q = {};
      repeat (9) q.push_back(8'h3E);
      run_load(q, 0, 0);
      run_load({8'h2D, 8'h2D}, 1000, 0);
      run_load({8'h61, 8'h5B, 8'h0A, 8'h5D, 8'h21}, 0, 0);
      pulse_start(0);
      send(8'h2B, 3, c);
      send(8'h2D, 3, c);
      run_load({8'h2E, 8'h21}, 0, 1);
      pulse_start(0);
      send(8'h2B, 3, c);
      send(8'h2D, 3, c);
      @(negedge clock);
      reset = 1;
      @(negedge clock);
      reset = 0;
      check_zero("midrst");
      run_load({8'h2E, 8'h21}, 0, 0);
      for (int n = 0; n < 25; n++) begin
         q = {};
         for (int i = 0, len = $urandom_range(1, 10); i < len; i++) begin
            case ($urandom_range(0, 9))
               0: q.push_back(8'h21);
               1: q.push_back(8'($urandom));
               default: q.push_back(pool[$urandom_range(0, 7)]);
            endcase
         end
         run_load(q, $urandom_range(0, 5), n % 4 == 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Sits directly downstream of uart_recv and upstream of the program sram inside top.
- Consumes received UART bytes and writes them into program memory at consecutive addresses starting from 0.
- Closes the program with a 0x00 end marker, then raises done so the interpreter core can start executing.

Parameters:
- ADDR_WIDTH, 10, program memory address width; depth = 2^ADDR_WIDTH; last address is reserved for the end marker.
- TERM_CHAR, 8'h21, byte that ends a load ('!'); the terminator itself is never stored.
- IDLE_TIMEOUT, 86800, clocks with no rx_valid (after the first byte) that end a load; 0 disables the timeout.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_load  in  1  level input (debounced button); a rising edge begins or restarts a load
- rx_data  in  8  received byte from uart_recv
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- mem_write  out  1  program sram write enable, one-cycle pulse
- mem_addr  out  ADDR_WIDTH  program sram address
- mem_data  out  8  program sram write data
- loading  out  1  high while a load is in progress
- done  out  1  high from end-marker write until the next load or reset
- overflow  out  1  the program exceeded capacity; bytes were dropped
- prog_len  out  ADDR_WIDTH  number of program bytes stored, excluding the end marker

Behaviour:
- Reset (synchronous): state=IDLE, all outputs 0, write pointer 0, timeout counter 0, start_load edge register 0.
- start_load edge detect: registered previous value; edge = start_load & ~prev.
- IDLE: rx_valid ignored. On edge -> WAIT_BYTE, with ptr=0, overflow=0, done=0, prog_len=0, loading=1.
- WAIT_BYTE, on rx_valid:
  - rx_data==TERM_CHAR -> TERM.
  - rx_data is a storable byte and ptr==2^ADDR_WIDTH-1 -> overflow=1, byte dropped, -> TERM.
  - rx_data is a storable byte otherwise -> byte latched, -> WRITE.
- WAIT_BYTE timeout: armed after the first accepted rx_valid of the load. The counter clears on every rx_valid and increments otherwise. When it reaches IDLE_TIMEOUT -> TERM.
- WRITE (exactly 1 cycle): mem_write=1, mem_addr=ptr, mem_data=latched byte; ptr++, prog_len++; -> WAIT_BYTE.
- Latency: rx_valid at cycle N gives mem_write at cycle N+1.
- rx_valid arriving in WRITE or TERM is dropped. uart_recv strobes are at least one byte-time apart, so this never occurs in normal operation.
- TERM (1 cycle): mem_write=1, mem_addr=ptr, mem_data=8'h00; loading=0, done=1; -> DONE.
- DONE: holds done=1, prog_len and overflow. An edge on start_load starts a new load (as from IDLE).
- Edge on start_load during WAIT_BYTE: the load restarts from ptr=0, overflow cleared, timeout disarmed. No end marker is written for the aborted load.
- Simultaneous start_load edge and rx_valid in WAIT_BYTE: the restart wins and the byte is dropped.
- Reset mid-load: next edge gives IDLE with mem_write=0; memory contents are undefined to the consumer because done=0.
- mem_addr and mem_data are registered. They hold their last value when mem_write=0.
- ptr never wraps: the maximum stored program is 2^ADDR_WIDTH-1 bytes, and the marker lands at the last address.

Optional Feature:
- Macro: LOADER_FILTER_EN.
- Defined: only the eight command bytes + - < > [ ] . , are storable. Any other non-terminator byte is discarded with no write and no ptr change, but it still clears and arms the timeout.
- Undefined: every byte other than TERM_CHAR is storable.

Test Plan:
- Reset, start_load edge, bytes '+','+','.','!' -> writes (0,0x2B),(1,0x2B),(2,0x2E),(3,0x00); done=1, prog_len=3, overflow=0.
- Each mem_write arrives exactly 1 clock after its rx_valid; no write ever occurs while in IDLE/DONE.
- ADDR_WIDTH=3, start_load edge, 9 bytes '>' with no '!' -> addresses 0..6 hold 0x3E, address 7 holds 0x00; prog_len=7, overflow=1, done=1; the 8th and 9th bytes produce no write.
- IDLE_TIMEOUT=100, bytes '-','-' then silence -> end marker written at address 2 exactly 100 clocks after the last rx_valid; no timeout fires before the first byte even after 1000 idle clocks.
- LOADER_FILTER_EN defined, bytes 'a','[','\n',']','!' -> only (0,0x5B),(1,0x5D),(2,0x00); prog_len=2. Undefined: 5 writes with prog_len=4.
- Reset asserted for 1 cycle mid-load after 2 bytes, then start_load edge and '.','!' -> writes (0,0x2E),(1,0x00); all outputs were 0 in the cycle after reset.
